// File: rtl/hazard_pkg.sv
// Shared types and constants for the decode-stage hazard controller.
package hazard_pkg;

    typedef logic [4:0] reg_idx_t;
    typedef logic [1:0] tcnt_t;

    // tuse value meaning "operand not read"
    localparam tcnt_t    TUSE_NONE    = 2'd3;
    localparam reg_idx_t REG_ZERO     = 5'd0;
    localparam int unsigned MULT_LAT_DEF = 5;
    localparam int unsigned DIV_LAT_DEF  = 10;

    // One in-flight producer: destination GPR and cycles until forwardable
    typedef struct packed {
        reg_idx_t dst;
        tcnt_t    tnew;
    } sb_entry_t;

    localparam sb_entry_t SB_EMPTY = '{REG_ZERO, 2'd0};

    // Remaining tnew after one more stage; saturates at zero
    function automatic tcnt_t age_tnew(tcnt_t t);
        return (t == 2'd0) ? 2'd0 : t - 2'd1;
    endfunction

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Decode-stage bundle between the ID stage (master) and the hazard controller (slave).
interface hazard_stall_ctrl_if;
    import hazard_pkg::*;

    reg_idx_t rs_d;
    reg_idx_t rt_d;
    tcnt_t    tuse_rs_d;
    tcnt_t    tuse_rt_d;
    reg_idx_t dst_d;
    tcnt_t    tnew_d;
    logic     md_start_d;
    logic     md_is_div_d;
    logic     md_use_d;
    logic     stall;
    logic     bubble;
    logic     md_start_e;
    logic     md_busy;

    modport master (
        output rs_d, rt_d, tuse_rs_d, tuse_rt_d, dst_d, tnew_d,
        output md_start_d, md_is_div_d, md_use_d,
        input  stall, bubble, md_start_e, md_busy
    );

    modport slave (
        input  rs_d, rt_d, tuse_rs_d, tuse_rt_d, dst_d, tnew_d,
        input  md_start_d, md_is_div_d, md_use_d,
        output stall, bubble, md_start_e, md_busy
    );

endinterface

// File: rtl/hazard_stall_ctrl_md_busy_counter.sv
// HI/LO unit busy window: loaded with the op latency on start, counts down to idle.
module md_busy_counter
    import hazard_pkg::*;
#(
    parameter int unsigned MULT_LAT = MULT_LAT_DEF,
    parameter int unsigned DIV_LAT  = DIV_LAT_DEF,
    parameter int unsigned CNT_W    = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_load,
    input  logic i_is_div,
    output logic o_busy
);

    localparam logic [CNT_W-1:0] MultCnt = CNT_W'(MULT_LAT);
    localparam logic [CNT_W-1:0] DivCnt  = CNT_W'(DIV_LAT);

    logic [CNT_W-1:0] r_count;

    // Load on start pulse, otherwise count down to zero; reset aborts the window
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_is_div ? DivCnt : MultCnt;
        end else if (r_count != '0) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign o_busy = (r_count != '0);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Decode-stage hazard controller: EX/MEM shadow scoreboard plus HI/LO busy tracking.
// Optional feature macro: HAZARD_STALL_MD_EN enables the HI/LO (mult/div) interlock;
// without it only GPR hazards stall and md_start_e/md_busy are tied low.
module hazard_stall_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned MULT_LAT = MULT_LAT_DEF,
    parameter int unsigned DIV_LAT  = DIV_LAT_DEF,
    parameter int unsigned CNT_W    = 4
) (
    input  logic               clk,
    input  logic               reset,
    hazard_stall_ctrl_if.slave bus
);

    sb_entry_t r_e;
    sb_entry_t r_m;
    sb_entry_t w_e_next;
    logic      w_rs_stall;
    logic      w_rt_stall;
    logic      w_md_stall;
    logic      w_stall;

    // Source hazards: E is checked first, but a hit in either entry stalls
    always_comb begin
        w_rs_stall = 1'b0;
        w_rt_stall = 1'b0;
        if (bus.rs_d != REG_ZERO && bus.tuse_rs_d != TUSE_NONE) begin
            if (r_e.dst == bus.rs_d && r_e.tnew > bus.tuse_rs_d) begin
                w_rs_stall = 1'b1;
            end else if (r_m.dst == bus.rs_d && r_m.tnew > bus.tuse_rs_d) begin
                w_rs_stall = 1'b1;
            end
        end
        if (bus.rt_d != REG_ZERO && bus.tuse_rt_d != TUSE_NONE) begin
            if (r_e.dst == bus.rt_d && r_e.tnew > bus.tuse_rt_d) begin
                w_rt_stall = 1'b1;
            end else if (r_m.dst == bus.rt_d && r_m.tnew > bus.tuse_rt_d) begin
                w_rt_stall = 1'b1;
            end
        end
    end

    assign w_stall    = w_rs_stall | w_rt_stall | w_md_stall;
    assign bus.stall  = w_stall;
    assign bus.bubble = w_stall;

    // A stalled D slot enters EX as an empty entry (the bubble)
    always_comb begin
        w_e_next = SB_EMPTY;
        if (!w_stall) begin
            w_e_next.dst  = bus.dst_d;
            w_e_next.tnew = bus.tnew_d;
        end
    end

    // Scoreboard advance: D -> E -> M, ageing tnew by one stage
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_e <= SB_EMPTY;
            r_m <= SB_EMPTY;
        end else begin
            r_e      <= w_e_next;
            r_m.dst  <= r_e.dst;
            r_m.tnew <= age_tnew(r_e.tnew);
        end
    end

`ifdef HAZARD_STALL_MD_EN
    logic r_md_start_e;
    logic r_md_is_div;
    logic w_md_busy;

    // Launch the HI/LO unit only when the md op actually leaves D
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_md_start_e <= 1'b0;
            r_md_is_div  <= 1'b0;
        end else begin
            r_md_start_e <= bus.md_start_d & ~w_stall;
            r_md_is_div  <= bus.md_is_div_d;
        end
    end

    md_busy_counter #(
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT),
        .CNT_W    (CNT_W)
    ) u_md_busy_counter (
        .clk      (clk),
        .reset    (reset),
        .i_load   (r_md_start_e),
        .i_is_div (r_md_is_div),
        .o_busy   (w_md_busy)
    );

    // Covers the start cycle too, so a HI/LO user never slips past the load
    assign w_md_stall     = bus.md_use_d & (r_md_start_e | w_md_busy);
    assign bus.md_start_e = r_md_start_e;
    assign bus.md_busy    = w_md_busy;
`else
    logic w_md_unused;

    assign w_md_unused    = ^{bus.md_start_d, bus.md_is_div_d, bus.md_use_d,
                              MULT_LAT[0], DIV_LAT[0], CNT_W[0]};
    assign w_md_stall     = 1'b0;
    assign bus.md_start_e = 1'b0;
    assign bus.md_busy    = 1'b0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl; honours HAZARD_STALL_MD_EN like the design.
module tb_hazard_stall_ctrl;

    localparam int unsigned MULT_LAT = 5;
    localparam int unsigned DIV_LAT  = 10;
    localparam int unsigned CNT_W    = 4;
`ifdef HAZARD_STALL_MD_EN
    localparam bit MD_EN = 1'b1;
`else
    localparam bit MD_EN = 1'b0;
`endif

    logic clk;
    logic reset;

    hazard_stall_ctrl_if bus ();

    hazard_stall_ctrl #(
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT),
        .CNT_W    (CNT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model: issued producers with absolute EX cycle and ready cycle
    typedef struct {
        int dst;
        int ex;
        int ready;
    } flight_t;
    flight_t fl[$];
    int md_ex  = -1000;
    int md_lat = 0;

    function automatic bit blocked(int src, int tuse);
        if (src == 0 || tuse == 3) return 1'b0;
        foreach (fl[i]) begin
            if (fl[i].dst == src && (fl[i].ex == cyc || fl[i].ex == cyc - 1) &&
                fl[i].ready > cyc + tuse) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Expected {stall, bubble, md_start_e, md_busy} for the current D slot
    function automatic logic [3:0] model_out();
        logic st, ms, mb;
        ms = MD_EN && (md_ex == cyc);
        mb = MD_EN && (cyc > md_ex) && (cyc <= md_ex + md_lat);
        st = blocked(int'(bus.rs_d), int'(bus.tuse_rs_d)) ||
             blocked(int'(bus.rt_d), int'(bus.tuse_rt_d)) ||
             (MD_EN && bus.md_use_d && (ms || mb));
        return {st, st, ms, mb};
    endfunction

    task automatic model_reset();
        fl.delete();
        md_ex  = -1000;
        md_lat = 0;
    endtask

    task automatic drive(input int rs, input int rt, input int tuse_rs, input int tuse_rt,
                         input int dst, input int tnew, input bit ms, input bit dv,
                         input bit mu);
        bus.rs_d        = 5'(rs);
        bus.rt_d        = 5'(rt);
        bus.tuse_rs_d   = 2'(tuse_rs);
        bus.tuse_rt_d   = 2'(tuse_rt);
        bus.dst_d       = 5'(dst);
        bus.tnew_d      = 2'(tnew);
        bus.md_start_d  = ms;
        bus.md_is_div_d = dv;
        bus.md_use_d    = mu;
        #1;
    endtask

    task automatic nop();
        drive(0, 0, 3, 3, 0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    function automatic logic [3:0] observed();
        return {bus.stall, bus.bubble, bus.md_start_e, bus.md_busy};
    endfunction

    // Clock edge: record what the model says leaves D, then move to the next slot
    task automatic advance();
        logic [3:0] e;
        flight_t    f;
        e = model_out();
        if (!e[3]) begin
            f.dst   = int'(bus.dst_d);
            f.ex    = cyc + 1;
            f.ready = cyc + 1 + int'(bus.tnew_d);
            fl.push_back(f);
            if (MD_EN && bus.md_start_d) begin
                md_ex  = cyc + 1;
                md_lat = bus.md_is_div_d ? int'(DIV_LAT) : int'(MULT_LAT);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        while (fl.size() > 0 && fl[0].ex < cyc - 1) void'(fl.pop_front());
    endtask

    task automatic test_reset();
        logic [3:0] got;
        reset = 1'b1;
        nop();
        repeat (2) @(posedge clk);
        #1;
        got = observed();
        n_vec++;
        if (got !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_state: outputs=%b want 0000", got);
        end
        drive(5, 6, 0, 0, 5, 2, 1'b1, 1'b1, 1'b1);
        got = observed();
        n_vec++;
        if (got !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_hold: outputs=%b want 0000", got);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        cyc = 0;
        nop();
        got = observed();
        n_vec++;
        if (got !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_release: outputs=%b want 0000", got);
        end
        advance();
    endtask

    task automatic test_reset_midstream();
        logic [3:0] got, want;
        drive(0, 0, 3, 3, 0, 0, 1'b1, 1'b1, 1'b1);
        got = observed();
        n_vec++;
        if (got !== 4'b0000) begin
            n_err++;
            $display("FAIL mid_div_issue: outputs=%b want 0000", got);
        end
        advance();
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 3, 3, 8, 2, 1'b0, 1'b0, 1'b0);
            want = model_out();
            got  = observed();
            n_vec++;
            if (got !== want) begin
                n_err++;
                $display("FAIL mid_fill[%0d]: outputs=%b want %b", i, got, want);
            end
            advance();
        end
        // E.dst=8 with tnew 2, div count at 7
        drive(8, 0, 1, 3, 0, 0, 1'b0, 1'b0, 1'b0);
        got = observed();
        n_vec++;
        if (got !== {2'b11, 1'b0, MD_EN}) begin
            n_err++;
            $display("FAIL mid_pre_reset: outputs=%b want %b", got, {2'b11, 1'b0, MD_EN});
        end
        reset = 1'b1;
        #1;
        got = observed();
        n_vec++;
        if (got !== 4'b0000) begin
            n_err++;
            $display("FAIL mid_async_reset: outputs=%b want 0000", got);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        cyc++;
        drive(8, 0, 1, 3, 0, 0, 1'b0, 1'b0, 1'b0);
        got = observed();
        n_vec++;
        if (got !== 4'b0000) begin
            n_err++;
            $display("FAIL mid_after_reset: outputs=%b want 0000", got);
        end
        advance();
    endtask

    task automatic test_load_use();
        logic [3:0] got, want;
        // load -> tuse 1 user: one bubble
        drive(0, 0, 3, 3, 8, 2, 1'b0, 1'b0, 1'b0);
        got = observed();
        n_vec++;
        if (got !== 4'b0000) begin
            n_err++;
            $display("FAIL load_issue: outputs=%b want 0000", got);
        end
        advance();
        for (int i = 0; i < 2; i++) begin
            drive(8, 0, 1, 3, 0, 0, 1'b0, 1'b0, 1'b0);
            want = (i == 0) ? 4'b1100 : 4'b0000;
            got  = observed();
            n_vec++;
            if (got !== want) begin
                n_err++;
                $display("FAIL load_use[%0d]: outputs=%b want %b", i, got, want);
            end
            advance();
        end
        // load -> beq on rt: two bubbles
        drive(0, 0, 3, 3, 8, 2, 1'b0, 1'b0, 1'b0);
        advance();
        for (int i = 0; i < 3; i++) begin
            drive(0, 8, 3, 0, 0, 0, 1'b0, 1'b0, 1'b0);
            want = (i < 2) ? 4'b1100 : 4'b0000;
            got  = observed();
            n_vec++;
            if (got !== want) begin
                n_err++;
                $display("FAIL load_beq[%0d]: outputs=%b want %b", i, got, want);
            end
            advance();
        end
    endtask

    task automatic test_alu_beq();
        logic [3:0] got, want;
        drive(0, 0, 3, 3, 9, 1, 1'b0, 1'b0, 1'b0);
        advance();
        for (int i = 0; i < 2; i++) begin
            drive(9, 0, 0, 3, 0, 0, 1'b0, 1'b0, 1'b0);
            want = (i == 0) ? 4'b1100 : 4'b0000;
            got  = observed();
            n_vec++;
            if (got !== want) begin
                n_err++;
                $display("FAIL alu_beq[%0d]: outputs=%b want %b", i, got, want);
            end
            advance();
        end
        drive(0, 0, 3, 3, 9, 1, 1'b0, 1'b0, 1'b0);
        advance();
        drive(9, 0, 1, 3, 0, 0, 1'b0, 1'b0, 1'b0);
        got = observed();
        n_vec++;
        if (got !== 4'b0000) begin
            n_err++;
            $display("FAIL alu_tuse1: outputs=%b want 0000", got);
        end
        advance();
    endtask

    task automatic test_reg_zero();
        logic [3:0] got;
        drive(0, 0, 3, 3, 0, 2, 1'b0, 1'b0, 1'b0);
        advance();
        drive(0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        got = observed();
        n_vec++;
        if (got !== 4'b0000) begin
            n_err++;
            $display("FAIL reg_zero: outputs=%b want 0000", got);
        end
        advance();
    endtask

    task automatic test_md(input bit is_div);
        logic [3:0] got, want;
        int lat, n_stall, n_busy, n_start;
        bit done;
        lat     = is_div ? int'(DIV_LAT) : int'(MULT_LAT);
        n_stall = 0;
        n_busy  = 0;
        n_start = 0;
        done    = 1'b0;
        drive(0, 0, 3, 3, 0, 0, 1'b1, is_div, 1'b1);
        got = observed();
        n_vec++;
        if (got !== 4'b0000) begin
            n_err++;
            $display("FAIL md_issue(div=%0b): outputs=%b want 0000", is_div, got);
        end
        advance();
        for (int i = 0; i < 30 && !done; i++) begin
            drive(0, 0, 3, 3, 0, 0, 1'b0, 1'b0, 1'b1);
            want = model_out();
            got  = observed();
            n_vec++;
            if (got !== want) begin
                n_err++;
                $display("FAIL md_user(div=%0b)[%0d]: outputs=%b want %b", is_div, i, got,
                         want);
            end
            n_stall += int'(got[3]);
            n_start += int'(got[1]);
            n_busy  += int'(got[0]);
            done = !got[3];
            advance();
        end
        n_vec++;
        if (!done) begin
            n_err++;
            $display("FAIL md_timeout(div=%0b): stall still high after 30 cycles", is_div);
        end
        n_vec++;
        if (n_stall != (MD_EN ? lat + 1 : 0)) begin
            n_err++;
            $display("FAIL md_stall_len(div=%0b): cycles=%0d want %0d", is_div, n_stall,
                     MD_EN ? lat + 1 : 0);
        end
        n_vec++;
        if (n_busy != (MD_EN ? lat : 0)) begin
            n_err++;
            $display("FAIL md_busy_len(div=%0b): cycles=%0d want %0d", is_div, n_busy,
                     MD_EN ? lat : 0);
        end
        n_vec++;
        if (n_start != (MD_EN ? 1 : 0)) begin
            n_err++;
            $display("FAIL md_start_pulses(div=%0b): pulses=%0d want %0d", is_div, n_start,
                     MD_EN ? 1 : 0);
        end
    endtask

    task automatic test_random();
        logic [3:0] got, want;
        bit ms, mu;
        for (int i = 0; i < 400; i++) begin
            ms = ($urandom_range(0, 15) == 0);
            mu = ms || ($urandom_range(0, 5) == 0);
            drive(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                  ms, $urandom_range(0, 1) == 1, mu);
            want = model_out();
            got  = observed();
            n_vec++;
            if (got !== want) begin
                n_err++;
                $display("FAIL random[%0d]: outputs=%b want %b rs=%0d/%0d rt=%0d/%0d", i, got,
                         want, bus.rs_d, bus.tuse_rs_d, bus.rt_d, bus.tuse_rt_d);
            end
            advance();
        end
    endtask

    initial begin
        test_reset();
        test_reset_midstream();
        test_load_use();
        test_alu_beq();
        test_reg_zero();
        test_md(1'b0);
        test_md(1'b1);
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/hazard_stall_ctrl.md
# hazard_stall_ctrl

Decode-stage hazard controller of the five-stage MIPS pipeline. Keeps a two-entry shadow scoreboard of destination registers and result-ready times for the instructions in EX and MEM. Tracks the HI/LO unit's multi-cycle busy window. Produces the stall that freezes PC and IF/ID, and the bubble flag that zeroes the instruction latched into ID/EX.

## Interface
Parameters:
- MULT_LAT, 5, busy cycles of mult/multu
- DIV_LAT, 10, busy cycles of div/divu
- CNT_W, 4, md counter width; must hold DIV_LAT

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-high
- rs_d, rt_d  in  5 each  source registers of the D instruction
- tuse_rs_d, tuse_rt_d  in  2 each  cycles until operand needed; 3 = not used
- dst_d  in  5  GPR written by the D instruction; 0 = none
- tnew_d  in  2  cycles in EX before result is forwardable (ALU 1, load 2, none 0)
- md_start_d  in  1  D is mult/multu/div/divu
- md_is_div_d  in  1  qualifies md_start_d
- md_use_d  in  1  D reads or writes HI/LO, or is itself an md op
- stall  out  1  hold PC and IF/ID
- bubble  out  1  zero the instruction entering ID/EX
- md_start_e  out  1  start pulse to the HI/LO unit
- md_busy  out  1  HI/LO unit computing

## Operation
- Scoreboard entries E{dst,tnew} and M{dst,tnew}.
- Each edge:
  - If stall=0: E <= {dst_d, tnew_d}. If stall=1: E <= {0,0}, which is the bubble.
  - M <= {E.dst, E.tnew==0 ? 0 : E.tnew-1}.
- Stall on rs when all hold:
  - rs_d != 0
  - tuse_rs_d != 3
  - either (E.dst==rs_d and E.tnew > tuse_rs_d) or (M.dst==rs_d and M.tnew > tuse_rs_d)
- Stall on rt uses the same rule.
- E is checked before M, but either match alone stalls.
- md_stall = md_use_d & (md_start_e | md_busy).
- stall = rs_stall | rt_stall | md_stall. bubble = stall.
- md_start_e <= md_start_d & ~stall. is_div is registered alongside it.
- Counter behaviour:
  - When md_start_e=1, count <= is_div ? DIV_LAT : MULT_LAT.
  - Otherwise, when count != 0, count <= count-1.
  - md_busy = (count != 0).
- A second md op in D while busy stalls through md_use_d, so it never restarts a running count.
- Register 0 never creates a dependency.

## Timing
- stall and bubble are combinational from D inputs and registered state, with zero latency.
- Reset values:
  - E, M = {0,0}
  - count = 0
  - md_start_e = 0
  - stall = bubble = md_busy = 0
- Reset mid-operation clears the scoreboard and aborts the busy window immediately; md_busy falls asynchronously.
- md window: the md op is in EX in cycle N with md_start_e=1. md_busy is high for cycles N+1..N+LAT. A HI/LO user in D stalls through cycle N+LAT and issues at N+LAT+1.
- A load followed by a dependent user with tuse 1 costs exactly one bubble. A tuse-0 user such as beq after a load costs two bubbles.

## Configuration
- HAZARD_STALL_MD_EN defined: md counter, md_start_e and md_stall are present as described.
- HAZARD_STALL_MD_EN undefined:
  - md_start_d, md_is_div_d and md_use_d are ignored.
  - md_start_e and md_busy are tied 0.
  - Only GPR hazards stall.

## Structure
- Shared package hazard_pkg holds:
  - TUSE_NONE = 3
  - default MULT_LAT and DIV_LAT
  - scoreboard entry type {dst[4:0], tnew[1:0]}
  - the register-0 constant
- Sub-module md_busy_counter contains the load/decrement counter and the md_busy output. It is instantiated only under HAZARD_STALL_MD_EN.
- The comparators and scoreboard stay in the top module.

## Test plan
- Assert reset mid-stream with E.dst=8, count=7 → all outputs 0 at once; the next D with rs=8 does not stall.
- Load-use:
  - D has dst=8, tnew=2; the next D has rs=8, tuse=1.
  - Required: stall=bubble=1 for exactly one cycle, then 0 (M.tnew=1).
- ALU→beq:
  - D has dst=9, tnew=1; the next D has rs=9, tuse=0.
  - Required: one stall cycle.
  - With tuse=1 instead: no stall.
- Register 0: D has dst=0, tnew=2; the next D has rs=0, rt=0, tuse=0 → no stall.
- mult then mflo:
  - md_start_d=1, md_is_div_d=0; the next D has md_use_d=1.
  - Required: md_start_e pulses one cycle; md_busy is high for 5 cycles; stall is high for 6 cycles.
  - The same with div: md_busy for 10 cycles, stall for 11.
- Build without HAZARD_STALL_MD_EN, repeat the mult→mflo case → stall stays 0 and md_busy stays 0.
